correction_seq: RTL and testbench

CORRECTION_SEQ -- requirements
Module: correction_seq

---
 rtl/correction_pkg.sv | 17 +
 rtl/correction_beat_cnt.sv | 36 +++
 rtl/correction_seq.sv | 131 +++++++++++++
 tb/tb_correction_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/correction_pkg.sv
// Shared definitions for the correction sequencer: phase encoding and
// default frame / LUT sizes for a 640x512 sensor.
package correction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LUT_LOAD = 3'd1,
        ST_FRAME_IN = 3'd2,
        ST_GAP      = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam int DEF_FRAME_PIXELS = 327680;
    localparam int DEF_LUT_WORDS    = 327680;

endpackage

// File: rtl/correction_beat_cnt.sv
// Beat counter shared by every phase: synchronous clear, count enable and a
// compare against the terminal value of the current phase.
module correction_beat_cnt #(
    parameter int CNT_WIDTH = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] term,
    output logic                 at_term
);

    logic [CNT_WIDTH-1:0] count_reg, count_next;

    // Clear wins over enable so a terminal beat never wraps the count.
    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            count_next = count_reg + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign at_term = (count_reg == term);

endmodule

// File: rtl/correction_seq.sv
// Sequencer for the pixel correction datapath: optional LUT load, frame
// ingest, pipeline gap, output drain and a one-cycle done pulse.
module correction_seq
    import correction_pkg::*;
#(
    parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
    parameter int LUT_WORDS    = DEF_LUT_WORDS,
    parameter int PIPE_LAT     = 20,
    parameter int CNT_WIDTH    = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       lut_reload,
    input  logic       abort,
    input  logic       lut_valid,
    output logic       lut_ready,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic       out_ready,
    output logic       nW,
    output logic       dInValid,
    output logic       dOutValid,
    output logic       busy,
    output logic       done,
    output logic [2:0] phase
);

    localparam logic [CNT_WIDTH-1:0] LUT_LAST   = CNT_WIDTH'(LUT_WORDS - 1);
    localparam logic [CNT_WIDTH-1:0] FRAME_LAST = CNT_WIDTH'(FRAME_PIXELS - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST   = CNT_WIDTH'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    state_t               state_reg, state_next;
    logic                 beat_en;
    logic                 beat_clr;
    logic                 at_term;
    logic [CNT_WIDTH-1:0] beat_term;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Terminal value depends only on the registered state, keeping the
    // compare out of the handshake path.
    always_comb begin
        beat_term = FRAME_LAST;
        case (state_reg)
            ST_LUT_LOAD: beat_term = LUT_LAST;
            ST_GAP:      beat_term = GAP_LAST;
            default:     beat_term = FRAME_LAST;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        lut_ready  = 1'b0;
        nW         = 1'b1;
        pix_ready  = 1'b0;
        dInValid   = 1'b0;
        dOutValid  = 1'b0;
        beat_en    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = lut_reload ? ST_LUT_LOAD : ST_FRAME_IN;
                end
            end
            ST_LUT_LOAD: begin
                lut_ready = 1'b1;
                nW        = ~lut_valid;
                beat_en   = lut_valid;
                if (lut_valid && at_term) begin
                    state_next = ST_FRAME_IN;
                end
            end
            ST_FRAME_IN: begin
                pix_ready = 1'b1;
                dInValid  = pix_valid;
                beat_en   = pix_valid;
                if (pix_valid && at_term) begin
                    state_next = (PIPE_LAT == 0) ? ST_DRAIN : ST_GAP;
                end
            end
            ST_GAP: begin
                beat_en = 1'b1;
                if (at_term) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                dOutValid = out_ready;
                beat_en   = out_ready;
                if (out_ready && at_term) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_next = ST_IDLE;
        end
    end

    // Every phase entry starts counting from zero.
    assign beat_clr = (state_next != state_reg) || abort;

    correction_beat_cnt #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_beat_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (beat_clr),
        .en     (beat_en),
        .term   (beat_term),
        .at_term(at_term)
    );

    assign busy  = (state_reg != ST_IDLE);
    assign done  = (state_reg == ST_DONE);
    assign phase = state_reg;

endmodule

// File: tb/tb_correction_seq.sv
// Randomized and directed checks of correction_seq against a beats-remaining
// reference model of the phase sequence.
module tb_correction_seq;
    import correction_pkg::*;

    localparam int FP = 16;
    localparam int LW = 8;
    localparam int PL = 3;
    localparam int CW = 19;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, lut_reload = 1'b0, abort = 1'b0;
    logic       lut_valid = 1'b0, pix_valid = 1'b0, out_ready = 1'b0;
    logic       lut_ready, pix_ready, nW, dInValid, dOutValid, busy, done;
    logic [2:0] phase;

    always #5 clk = ~clk;

    correction_seq #(
        .FRAME_PIXELS(FP),
        .LUT_WORDS   (LW),
        .PIPE_LAT    (PL),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .lut_reload(lut_reload),
        .abort     (abort),
        .lut_valid (lut_valid),
        .lut_ready (lut_ready),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .out_ready (out_ready),
        .nW        (nW),
        .dInValid  (dInValid),
        .dOutValid (dOutValid),
        .busy      (busy),
        .done      (done),
        .phase     (phase)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: current phase plus beats still owed in that phase.
    state_t m_ph;
    int     m_left;

    function automatic logic [9:0] model_out(input logic lv, input logic pv, input logic orr);
        model_out = {m_ph != ST_IDLE, m_ph == ST_DONE, m_ph,
                     !(m_ph == ST_LUT_LOAD && lv), m_ph == ST_LUT_LOAD,
                     m_ph == ST_FRAME_IN, m_ph == ST_FRAME_IN && pv,
                     m_ph == ST_DRAIN && orr};
    endfunction

    task automatic model_next(input logic st, input logic rl, input logic lv, input logic pv,
                              input logic orr, input logic ab, input logic rs);
        if (rs || ab) begin
            m_ph   = ST_IDLE;
            m_left = 0;
        end else begin
            case (m_ph)
                ST_IDLE: if (st) begin
                    m_ph   = rl ? ST_LUT_LOAD : ST_FRAME_IN;
                    m_left = rl ? LW : FP;
                end
                ST_LUT_LOAD: if (lv) begin
                    m_left--;
                    if (m_left == 0) begin m_ph = ST_FRAME_IN; m_left = FP; end
                end
                ST_FRAME_IN: if (pv) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (PL > 0) begin m_ph = ST_GAP; m_left = PL; end
                        else begin m_ph = ST_DRAIN; m_left = FP; end
                    end
                end
                ST_GAP: begin
                    m_left--;
                    if (m_left == 0) begin m_ph = ST_DRAIN; m_left = FP; end
                end
                ST_DRAIN: if (orr) begin
                    m_left--;
                    if (m_left == 0) m_ph = ST_DONE;
                end
                default: m_ph = ST_IDLE;
            endcase
        end
    endtask

    // One clock: drive at negedge, compare combinational outputs, advance model.
    task automatic step(input logic st, input logic rl, input logic lv, input logic pv,
                        input logic orr, input logic ab, input logic rs,
                        input string tag, output logic [9:0] got_v);
        logic [9:0] exp_v;
        @(negedge clk);
        start = st; lut_reload = rl; lut_valid = lv; pix_valid = pv;
        out_ready = orr; abort = ab; rst = rs;
        #1;
        exp_v = model_out(lv, pv, orr);
        got_v = {busy, done, phase, nW, lut_ready, pix_ready, dInValid, dOutValid};
        chk(tag, int'(got_v), int'(exp_v));
        model_next(st, rl, lv, pv, orr, ab, rs);
    endtask

    int         r_nw, r_din, r_dout, r_frm, r_dout_frm, r_done_at, r_first_din;
    logic [9:0] r_after;

    // mode 0: all valid/ready high, 1: pix_valid toggles, 2: random everything.
    task automatic run(input string name, input logic rl_in, input int mode, input int len,
                       input int stall_at, input int ev_at, input logic ev_rst);
        logic [9:0] g;
        logic       rl;
        r_nw = 0; r_din = 0; r_dout = 0; r_frm = 0; r_dout_frm = 0;
        r_done_at = -1; r_first_din = -1; r_after = '1;
        rl = rl_in;
        for (int off = 0; off < len; off++) begin
            logic st, lv, pv, orr, ab, rs;
            st  = (off == 0) || (ev_rst && off == ev_at);
            lv  = 1'b1;
            pv  = 1'b1;
            orr = 1'b1;
            ab  = !ev_rst && off == ev_at;
            rs  = ev_rst && off == ev_at;
            if (mode == 1) pv = (off % 2 == 0);
            if (mode == 2) begin
                lv  = ($urandom_range(0, 3) != 0);
                pv  = ($urandom_range(0, 3) != 0);
                orr = ($urandom_range(0, 3) != 0);
                st  = (off == 0) || ($urandom_range(0, 15) == 0);
                rl  = ($urandom_range(0, 1) == 1);
                ab  = ($urandom_range(0, 63) == 0);
            end
            if (stall_at >= 0 && off >= stall_at && off < stall_at + 5) orr = 1'b0;
            step(st, rl, lv, pv, orr, ab, rs, name, g);
            if (!g[4]) r_nw++;
            if (g[1]) r_din++;
            if (g[0]) r_dout++;
            if (g[7:5] == ST_FRAME_IN) begin
                r_frm++;
                if (g[0]) r_dout_frm++;
            end
            if (g[8] && r_done_at < 0) r_done_at = off;
            if (g[1] && r_first_din < 0) r_first_din = off;
            if (off == ev_at + 1) r_after = g;
        end
        $display("run %s: done_at=%0d nw=%0d din=%0d dout=%0d frame_cyc=%0d",
                 name, r_done_at, r_nw, r_din, r_dout, r_frm);
    endtask

    logic [9:0] idle_vec;
    logic [9:0] g0;

    initial begin
        idle_vec = {1'b0, 1'b0, ST_IDLE, 5'b10000};
        m_ph   = ST_IDLE;
        m_left = 0;
        rst    = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "reset", g0);
        chk("reset_state", int'(g0), int'(idle_vec));

        run("full", 1'b1, 0, 50, -1, -1, 1'b0);
        chk("full_nw", r_nw, LW);
        chk("full_din", r_din, FP);
        chk("full_dout", r_dout, FP);
        chk("full_done_at", r_done_at, 44);

        run("nolut", 1'b0, 0, 42, -1, -1, 1'b0);
        chk("nolut_nw", r_nw, 0);
        chk("nolut_first_din", r_first_din, 1);
        chk("nolut_done_at", r_done_at, 36);

        run("toggle", 1'b0, 1, 58, -1, -1, 1'b0);
        chk("toggle_din", r_din, FP);
        chk("toggle_frame_cyc", r_frm, 32);
        chk("toggle_dout_in_frame", r_dout_frm, 0);
        chk("toggle_done_at", r_done_at, 52);

        run("stall", 1'b0, 0, 46, 25, -1, 1'b0);
        chk("stall_dout", r_dout, FP);
        chk("stall_done_at", r_done_at, 41);

        run("abort", 1'b1, 0, 12, -1, 5, 1'b0);
        chk("abort_done", r_done_at, -1);
        chk("abort_nw", r_nw, 5);
        chk("abort_after", int'(r_after), int'(idle_vec));

        run("restart", 1'b1, 0, 50, -1, -1, 1'b0);
        chk("restart_nw", r_nw, LW);
        chk("restart_done_at", r_done_at, 44);

        run("rst_drain", 1'b0, 0, 32, -1, 25, 1'b1);
        chk("rst_drain_done", r_done_at, -1);
        chk("rst_drain_after", int'(r_after), int'(idle_vec));

        for (int k = 0; k < 6; k++) begin
            run("random", 1'b1, 2, 150, -1, -1, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "cleanup", g0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "final", g0);
        chk("final_idle", int'(g0), int'(idle_vec));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
